// File: rtl/product_arbiter_if.sv
// Bundle of request, product-unit and response signals for product_arbiter.
// The slave modport is the arbiter's view; master is the requester/environment view.
interface product_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    ip_req_valid;
  logic [2*NUM_REQ-1:0]  ip_req_coef;
  logic [12*NUM_REQ-1:0] ip_req_data;
  logic [NUM_REQ-1:0]    op_req_ready;
  logic [1:0]            op_mul_coef;
  logic [11:0]           op_mul_data;
  logic [11:0]           ip_mul_result;
  logic                  op_rsp_valid;
  logic [2:0]            op_rsp_tag;
  logic [11:0]           op_rsp_data;
  logic                  ip_rsp_ready;
  logic                  op_busy;

  modport slave (
    input  ip_req_valid, ip_req_coef, ip_req_data, ip_mul_result, ip_rsp_ready,
    output op_req_ready, op_mul_coef, op_mul_data, op_rsp_valid, op_rsp_tag,
           op_rsp_data, op_busy
  );

  modport master (
    output ip_req_valid, ip_req_coef, ip_req_data, ip_mul_result, ip_rsp_ready,
    input  op_req_ready, op_mul_coef, op_mul_data, op_rsp_valid, op_rsp_tag,
           op_rsp_data, op_busy
  );
endinterface

// File: rtl/product_arbiter.sv
// Round-robin arbiter in front of a shared 1-cycle product unit. Each grant is
// tracked for one cycle in an in-flight register, then its result is written
// (with the requester index as tag) into a small first-word-fall-through FIFO.
// Grants are credit-limited so the FIFO can never overflow.
module product_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic ip_clock,
  input  logic ip_reset,
  product_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // State
  logic [PW-1:0] last_q, last_d;
  logic          inflight_q, inflight_d;
  logic [2:0]    inflight_tag_q, inflight_tag_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  // Response storage; tag and data kept side by side per entry
  logic [2:0]  mem_tag  [FIFO_DEPTH];
  logic [11:0] mem_data [FIFO_DEPTH];

  // Per-requester fields unpacked from the flat buses
  logic [1:0]  coef_arr [NUM_REQ];
  logic [11:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign coef_arr[gi] = bus.ip_req_coef[2*gi +: 2];
    assign data_arr[gi] = bus.ip_req_data[12*gi +: 12];
  end

  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic          rsp_valid;
  logic          pop;
  logic          credit_ok;
  logic          grant;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(last_q) + k) % NUM_REQ);
      if (!grant_found && bus.ip_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Credit check counts the same-cycle pop so a draining FIFO can refill at once
  always_comb begin
    rsp_valid = (count_q != '0) && !ip_reset;
    pop       = rsp_valid && bus.ip_rsp_ready;
    credit_ok = (int'(count_q) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
    grant     = grant_found && credit_ok && !ip_reset;
  end

  // Grant and product-unit operand drive; operands are zero when idle
  always_comb begin
    bus.op_req_ready = '0;
    bus.op_mul_coef  = '0;
    bus.op_mul_data  = '0;
    if (grant) begin
      bus.op_req_ready = NUM_REQ'(1) << grant_idx;
      bus.op_mul_coef  = coef_arr[grant_idx];
      bus.op_mul_data  = data_arr[grant_idx];
    end
  end

  // Head of the FIFO is presented directly (fall-through)
  always_comb begin
    bus.op_rsp_valid = rsp_valid;
    bus.op_rsp_tag   = mem_tag[rd_q];
    bus.op_rsp_data  = mem_data[rd_q];
    bus.op_busy      = (inflight_q || (count_q != '0)) && !ip_reset;
  end

  // Next-state: pointer update, in-flight capture, FIFO bookkeeping
  always_comb begin
    last_d         = grant ? grant_idx : last_q;
    inflight_d     = grant;
    inflight_tag_d = grant ? 3'(grant_idx) : inflight_tag_q;
    wr_d           = inflight_q ? AW'(wr_q + 1'b1) : wr_q;
    rd_d           = pop ? AW'(rd_q + 1'b1) : rd_q;
    count_d        = count_q + CW'(inflight_q) - CW'(pop);
  end

  // Control registers with synchronous reset; reset drops anything in flight
  always_ff @(posedge ip_clock) begin
    if (ip_reset) begin
      last_q         <= PW'(NUM_REQ - 1);
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      count_q        <= '0;
    end else begin
      last_q         <= last_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      count_q        <= count_d;
    end
  end

  // FIFO storage write: the product result arrives one cycle after issue
  always_ff @(posedge ip_clock) begin
    if (!ip_reset && inflight_q) begin
      mem_tag[wr_q]  <= inflight_tag_q;
      mem_data[wr_q] <= bus.ip_mul_result;
    end
  end
endmodule

// File: doc/product_arbiter.md
PRODUCT_ARBITER -- requirements
Module: product_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the response buffer entries (power of two, >=2).
REQ-003 The block SHALL have port ip_clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port ip_reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port ip_req_valid, input, NUM_REQ bits, one request-valid per requester.
REQ-006 The block SHALL have port ip_req_coef, input, 2*NUM_REQ bits, the 2-bit coefficient of requester i at bits [2i+1:2i].
REQ-007 The block SHALL have port ip_req_data, input, 12*NUM_REQ bits, the 12-bit signed operand of requester i at bits [12i+11:12i].
REQ-008 The block SHALL have port op_req_ready, output, NUM_REQ bits, a one-hot or zero grant; a transfer occurs when valid and ready are both high.
REQ-009 The block SHALL have port op_mul_coef, output, 2 bits, the coefficient to the shared product unit.
REQ-010 The block SHALL have port op_mul_data, output, 12 bits, the operand to the shared product unit.
REQ-011 The block SHALL have port ip_mul_result, input, 12 bits, the product unit result, valid exactly 1 cycle after issue.
REQ-012 The block SHALL have port op_rsp_valid, output, 1 bit, response available.
REQ-013 The block SHALL have port op_rsp_tag, output, 3 bits, index of the originating requester.
REQ-014 The block SHALL have port op_rsp_data, output, 12 bits, result passed through unmodified.
REQ-015 The block SHALL have port ip_rsp_ready, input, 1 bit, consumer accept; a pop occurs when valid and ready are both high.
REQ-016 The block SHALL have port op_busy, output, 1 bit, high while any issue is in flight or the FIFO is non-empty.

Function
REQ-017 Arbitration SHALL be round-robin: the search starts at the index after the last granted requester and wraps modulo NUM_REQ; the last-grant pointer resets to NUM_REQ-1, so requester 0 has first priority.
REQ-018 At most one op_req_ready bit SHALL be high per cycle, and only for a requester whose valid bit is high in that cycle (combinational grant).
REQ-019 A grant SHALL be given only when credit exists: fifo_count + inflight - pop < FIFO_DEPTH, where pop is the same-cycle response pop.
REQ-020 On a granted transfer, op_mul_coef and op_mul_data SHALL carry the granted requester's fields in that cycle; when there is no grant they SHALL be driven to 0.
REQ-021 The issue SHALL be recorded in a 1-stage in-flight register (valid + tag); on the next edge ip_mul_result SHALL be written with that tag into the FIFO.
REQ-022 The FIFO SHALL be first-word-fall-through: op_rsp_valid = (count != 0), with op_rsp_tag and op_rsp_data taken from the head entry.
REQ-023 A simultaneous FIFO write and pop SHALL leave the count unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 The FIFO SHALL never overflow under any ip_rsp_ready pattern, which is guaranteed by REQ-019.
REQ-025 With ip_rsp_ready held high and continuous requests, throughput SHALL be one issue per cycle; the latency from grant to op_rsp_valid SHALL be 2 cycles.
REQ-026 The last-grant pointer SHALL update only on a granted transfer.
REQ-027 The result SHALL be passed through unmodified; the block performs no arithmetic on the data path.

Reset
REQ-028 While ip_reset is high at a rising edge, the following SHALL clear on the next state: in-flight valid, FIFO count, and FIFO pointers, and the last-grant pointer SHALL go to NUM_REQ-1.
REQ-029 During reset, op_req_ready, op_rsp_valid, and op_busy SHALL be 0, and op_mul_coef and op_mul_data SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard in-flight and buffered results, with no response emitted afterward.

Verification
REQ-031 Single request: req0 valid, coef=2'b01, data=12'h123, rsp_ready=1 -> ready0 in cycle 0; op_rsp_valid in cycle 2 with tag 0 and data equal to the unit's result.
REQ-032 All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; tags in that order.
REQ-033 Backpressure: rsp_ready=0 with 4 requesters valid -> exactly 2 grants, then op_req_ready=0 until a pop; the first pop re-enables exactly one grant in the same cycle.
REQ-034 Sparse fairness: req1 and req3 valid, pointer at 1 -> grant 3, then 1, then 3; req0 and req2 never granted.
REQ-035 Reset mid-flight: a grant in cycle N, reset in cycle N+1 -> op_rsp_valid=0 and op_busy=0 from cycle N+2; next grant goes to req0.
REQ-036 Simultaneous write and pop with FIFO at count 1 -> count stays 1 and the order is preserved across pointer wrap.
